// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with a Mealy match and a registered copy.
// Define SEQ_DETECT_PARAM_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module seq_detect_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PAT = 8'b0000_1011,
  parameter int unsigned          DEFAULT_LEN = 4,
  localparam int unsigned         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic               in,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  output logic               match,
`ifdef SEQ_DETECT_PARAM_CNT_EN
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr,
`endif
  output logic               match_q
);

  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FillMax = LEN_W'(MAX_LEN - 1);

  if (MAX_LEN < 1 || CNT_W < 1 || DEFAULT_LEN < 1 || DEFAULT_LEN > MAX_LEN) begin : g_cfg_err
    $error("seq_detect_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {StDis, StFill, StArmed} state_e;

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;

  logic               accepted;
  logic               armed;
  logic               hit;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;

  always_comb begin
    accepted = en & in_valid & ~pat_load;
    window   = MAX_LEN'({hist_q, in});
    mask     = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    hit = (((window ^ pat_q) & mask) == '0);
    // FILL already holding len-1 bits behaves as armed, so len=1 matches right after a restart.
    armed = (state_q == StArmed) ||
            ((state_q == StFill) && (fill_q >= len_q - LenOne));
    match = accepted & armed & hit;

    fill_inc = fill_q;
    if (accepted && (fill_q != FillMax)) begin
      fill_inc = fill_q + LenOne;
    end

    len_clamped = len_in;
    if (len_in == '0) begin
      len_clamped = LenOne;
    end else if (len_in > LenMax) begin
      len_clamped = LenMax;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StDis;
      pat_q   <= DEFAULT_PAT;
      len_q   <= LEN_W'(DEFAULT_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= match;
      if (accepted) begin
        hist_q <= window;
      end
      if (pat_load) begin
        // Restarting on load keeps a new length from comparing stale history.
        pat_q   <= pat_in;
        len_q   <= len_clamped;
        fill_q  <= '0;
        state_q <= en ? StFill : StDis;
      end else if (!en) begin
        fill_q  <= '0;
        state_q <= StDis;
      end else begin
        case (state_q)
          StDis: begin
            fill_q  <= '0;
            state_q <= StFill;
          end
          StFill, StArmed: begin
            if (match && !overlap && (len_q != LenOne)) begin
              fill_q  <= '0;
              state_q <= StFill;
            end else begin
              fill_q <= fill_inc;
              if (fill_inc >= len_q - LenOne) begin
                state_q <= StArmed;
              end
            end
          end
          default: begin
            fill_q  <= '0;
            state_q <= StDis;
          end
        endcase
      end
    end
  end

`ifdef SEQ_DETECT_PARAM_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param; counter checks run when
// SEQ_DETECT_PARAM_CNT_EN is defined.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       din;
  logic       overlap;
  logic       pat_load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       match;
  logic       match_q;
`ifdef SEQ_DETECT_PARAM_CNT_EN
  logic [1:0] match_cnt;
  logic       cnt_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic prev_m = 1'b0;

  seq_detect_param #(
    .MAX_LEN    (8),
    .CNT_W      (2),
    .DEFAULT_PAT(8'b0000_1011),
    .DEFAULT_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in       (din),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .len_in   (len_in),
    .match    (match),
`ifdef SEQ_DETECT_PARAM_CNT_EN
    .match_cnt(match_cnt),
    .cnt_clr  (cnt_clr),
`endif
    .match_q  (match_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at the falling edge.
  task automatic cyc(input logic e, input logic v, input logic b, input logic ld,
                     input logic exp_m, input string tag);
    en       = e;
    in_valid = v;
    din      = b;
    pat_load = ld;
    #4;
    check_eq(tag, {31'd0, match}, {31'd0, exp_m});
    check_eq({tag, "_q"}, {31'd0, match_q}, {31'd0, prev_m});
    prev_m = exp_m;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b1, 1'b1, bits[i], 1'b0, exp[i], $sformatf("%s_b%0d", tag, n - i));
    end
  endtask

  task automatic idle(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(e, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic v, input logic b);
    pat_in = p;
    len_in = l;
    cyc(1'b1, v, b, 1'b1, 1'b0, "load");
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b1;
    in_valid = 1'b1;
    din      = 1'b1;
    overlap  = 1'b0;
    pat_load = 1'b0;
    pat_in   = '0;
    len_in   = '0;
`ifdef SEQ_DETECT_PARAM_CNT_EN
    cnt_clr  = 1'b0;
`endif
    @(posedge clk);
    #5;
    check_eq("rst_match", {31'd0, match}, 32'd0);
    check_eq("rst_match_q", {31'd0, match_q}, 32'd0);
`ifdef SEQ_DETECT_PARAM_CNT_EN
    check_eq("rst_cnt", {30'd0, match_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1, 1'b1, "arm");

    // Default pattern 1011, non-overlapping
    stream(16'b1011011, 16'b0001000, 7, "nov");
    idle(1, 1'b0, "dis");
    idle(1, 1'b1, "reen");

    // Same stream, overlapping
    overlap = 1'b1;
    stream(16'b1011011, 16'b0001001, 7, "ovl");

    // Load 8-bit pattern; the same-cycle data bit is dropped
    overlap = 1'b0;
    load(8'b1110_0101, 4'd8, 1'b1, 1'b1);
    stream(16'b11100101, 16'b00000001, 8, "len8");

    // Over-range length clamps to 8
    load(8'b1110_0101, 4'd15, 1'b0, 1'b0);
    stream(16'b11100101, 16'b00000001, 8, "clamp");

    // Zero length becomes 1
    load(8'b0000_0001, 4'd0, 1'b0, 1'b0);
    stream(16'b1101, 16'b1101, 4, "len1");

    // Pattern straddling a gap, then the same with en dropped in the gap
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
    stream(16'b10, 16'b00, 2, "gapa");
    idle(5, 1'b1, "gap");
    stream(16'b11, 16'b01, 2, "gapb");
    stream(16'b10, 16'b00, 2, "gdisa");
    idle(5, 1'b0, "gdis");
    idle(1, 1'b1, "gen");
    stream(16'b11, 16'b00, 2, "gdisb");

`ifdef SEQ_DETECT_PARAM_CNT_EN
    load(8'b0000_0001, 4'd1, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    idle(1, 1'b1, "clr");
    cnt_clr = 1'b0;
    check_eq("cnt_clr0", {30'd0, match_cnt}, 32'd0);
    stream(16'b111, 16'b111, 3, "cnt");
    check_eq("cnt_3", {30'd0, match_cnt}, 32'd3);
    stream(16'b11, 16'b11, 2, "sat");
    check_eq("cnt_sat", {30'd0, match_cnt}, 32'd3);
    cnt_clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "clr_hit");
    cnt_clr = 1'b0;
    check_eq("cnt_clr_hit", {30'd0, match_cnt}, 32'd0);
    stream(16'b1, 16'b1, 1, "inc");
    check_eq("cnt_1", {30'd0, match_cnt}, 32'd1);
`endif

    // Reset in the middle of a pattern
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
    stream(16'b10, 16'b00, 2, "mida");
    in_valid = 1'b0;
    rst = 1'b0;
    #4;
    check_eq("midrst_match", {31'd0, match}, 32'd0);
    check_eq("midrst_match_q", {31'd0, match_q}, 32'd0);
`ifdef SEQ_DETECT_PARAM_CNT_EN
    check_eq("midrst_cnt", {30'd0, match_cnt}, 32'd0);
`endif
    prev_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1, 1'b1, "rel");
    stream(16'b11, 16'b00, 2, "midb");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Runtime-programmable serial pattern detector, the parametrised successor to the team's fixed four-bit Mealy sequence detectors. It supports a loadable pattern of 1..MAX_LEN bits and a per-cycle overlapping/non-overlapping mode select. It provides two outputs: a combinational Mealy match and a registered copy. A saturating match counter is optional. It sits on a one-bit serial stream qualified by `in_valid`, for example after a deserialiser or line decoder, and feeds an interrupt or statistics block.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥1).
- `CNT_W`, 16: match counter width.
- `DEFAULT_PAT`, 8'b0000_1011: pattern after reset, MAX_LEN bits wide.
- `DEFAULT_LEN`, 4: pattern length after reset (1..MAX_LEN).
- `LEN_W`: localparam, $clog2(MAX_LEN+1).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: detector enable.
- `in_valid`, in, 1: `in` carries a stream bit this cycle.
- `in`, in, 1: serial data bit.
- `overlap`, in, 1: 1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- `pat_load`, in, 1: load `pat_in`/`len_in` this cycle.
- `pat_in`, in, MAX_LEN: new pattern; bit [len-1] is the first bit received.
- `len_in`, in, LEN_W: new length.
- `match`, out, 1: combinational Mealy match for the current bit.
- `match_q`, out, 1: `match` registered by one cycle.
- `match_cnt`, out, CNT_W: saturating match count (present only with the macro).
- `cnt_clr`, in, 1: synchronous counter clear (present only with the macro).

## Operation
- Registers:
  - `pat` and `len`: current pattern and length.
  - `hist`: MAX_LEN-bit history; shifts left with the new bit entering at LSB.
  - `fill`: 0..MAX_LEN-1; counts valid history bits since the last restart, saturating.
- An accepted bit is `en & in_valid & ~pat_load`. Only accepted bits shift `hist` and advance `fill`.
- FSM has three states.
  - DIS: entered when `en`=0 from any state. Clears `fill`. `match`=0. Moves to FILL when `en`=1.
  - FILL: counts accepted bits. Moves to ARMED once `fill` ≥ `len`-1. With `len`=1 it moves to ARMED in the first enabled cycle.
  - ARMED: `match` = accepted bit & ({hist, in} low `len` bits == `pat` low `len` bits).
- On match with `overlap`=0: `fill` ← 0 and the FSM moves to FILL. Exception: with `len`=1 it stays in ARMED.
- On match with `overlap`=1: the FSM stays in ARMED and `hist` continues shifting.
- Pattern load (`pat_load`=1):
  - `pat` ← `pat_in`.
  - `len` ← `len_in` clamped to [1, MAX_LEN]; 0 becomes 1.
  - `fill` ← 0; FSM moves to FILL, or to DIS if `en`=0.
  - The same-cycle `in` bit is discarded and `match`=0 for that cycle.
- A `len` change never compares stale history: the restart on load guarantees this.

## Timing
- Reset values:
  - `pat`=DEFAULT_PAT, `len`=DEFAULT_LEN, `hist`=0, `fill`=0.
  - FSM=DIS, `match_q`=0, `match_cnt`=0.
  - `match` is 0 while reset is asserted.
- Latency:
  - `match` asserts in the same cycle as the last pattern bit (zero latency, combinational from `in`, `in_valid`, `en`, `pat_load`).
  - `match_q` asserts one cycle later.
- Gaps (`in_valid`=0) hold all state; a pattern may straddle any number of gap cycles.
- `overlap` toggling mid-stream takes effect at the next match; no restart.
- Reset asserted mid-pattern aborts it immediately. Partial history is never matched after reset release.

## Configuration
- `SEQ_DETECT_PARAM_CNT_EN` defined:
  - `match_cnt` and `cnt_clr` exist.
  - The counter increments on each `match` and saturates at 2^CNT_W−1.
  - `cnt_clr` has priority: `cnt_clr` together with `match` yields 0.
- Not defined: both ports and the counter logic are absent. `match` and `match_q` behave identically either way.

## Test plan
- Reset defaults, `overlap`=0, `en`=1, stream 1,0,1,1,0,1,1 with `in_valid` every cycle → `match` only on bit 4; `match_q` on the cycle after bit 4.
- Same stream with `overlap`=1 → `match` on bits 4 and 7.
- Load `pat_in`=8'b1110_0101, `len_in`=8 with a data bit in the same cycle → that bit is ignored. The following 8 bits 1,1,1,0,0,1,0,1 → `match` on the 8th bit only.
- `len_in`=0 loaded with `pat_in` LSB=1 → `len` becomes 1; stream 1,1,0,1 in non-overlap mode → `match` on bits 1, 2 and 4.
- Stream 1,0 then `in_valid`=0 for 5 cycles, then 1,1 → `match` on the final bit. Repeat with `en` dropped during the gap → no match.
- With the macro and CNT_W=2: 5 matches → `match_cnt` saturates at 3. `cnt_clr` in the same cycle as a match → 0. Reset mid-pattern → `match_cnt`=0 and no match on the remaining bits.
